// File: rtl/beat_sequencer.sv
// Beat/timing generator and run controller: one-hot W beats with SHORT/LONG/STOP handling,
// step mode and an instruction counter. Optional PC breakpoint: define BEAT_SEQ_BREAKPOINT_EN.
module beat_sequencer #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 8
) (
  input  logic             i_t3,
  input  logic             i_clr,
  input  logic             i_qd,
  input  logic             i_step,
  input  logic             i_short,
  input  logic             i_long,
  input  logic             i_stop,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [PC_W-1:0]  i_brk_addr,
  input  logic             i_brk_ena,
  output logic [2:0]       o_w,
  output logic             o_running,
  output logic             o_halted,
  output logic             o_brk_hit,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_w;
  logic [2:0]       r_resume;
  logic             r_qd_q;
  logic [CNT_W-1:0] r_cnt;

  logic       w_eoi;
  logic [2:0] w_next;
  logic       w_qd_rise;
  logic       w_brk;
  logic       w_pause;

  // Next beat from the current one; an illegal/empty W falls back to W1 without ending an instruction.
  always_comb begin
    w_eoi  = 1'b0;
    w_next = 3'b001;
    case (r_w)
      3'b001: begin
        w_eoi  = i_short;
        w_next = i_short ? 3'b001 : 3'b010;
      end
      3'b010: begin
        w_eoi  = ~i_long;
        w_next = i_long ? 3'b100 : 3'b001;
      end
      3'b100: begin
        w_eoi  = 1'b1;
        w_next = 3'b001;
      end
      default: ;
    endcase
  end

  assign w_qd_rise = i_qd & ~r_qd_q;

`ifdef BEAT_SEQ_BREAKPOINT_EN
  logic r_brk_hit;

  assign w_brk = w_eoi & i_brk_ena & (i_pc == i_brk_addr);

  always_ff @(negedge i_t3 or negedge i_clr) begin
    if (!i_clr) begin
      r_brk_hit <= 1'b0;
    end else if (r_state == ST_RUN && w_pause) begin
      r_brk_hit <= w_brk;
    end else if (r_state == ST_PAUSE && w_qd_rise) begin
      r_brk_hit <= 1'b0;
    end
  end

  assign o_brk_hit = r_brk_hit;
`else
  logic w_unused_brk;

  assign w_unused_brk = ^{i_pc, i_brk_addr, i_brk_ena};
  assign w_brk        = 1'b0;
  assign o_brk_hit    = 1'b0;
`endif

  assign w_pause = i_stop | (i_step & w_eoi) | w_brk;

  always_ff @(negedge i_t3 or negedge i_clr) begin
    if (!i_clr) begin
      r_state  <= ST_IDLE;
      r_w      <= 3'b000;
      r_resume <= 3'b001;
      r_qd_q   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_qd_q <= i_qd;
      case (r_state)
        ST_IDLE: begin
          if (w_qd_rise) begin
            r_state <= ST_RUN;
            r_w     <= 3'b001;
          end
        end
        ST_RUN: begin
          if (w_eoi) r_cnt <= r_cnt + CNT_W'(1);
          // A breakpoint only fires at end-of-instr, where the next beat is already W1.
          if (w_pause) begin
            r_state  <= ST_PAUSE;
            r_w      <= 3'b000;
            r_resume <= w_next;
          end else begin
            r_w <= w_next;
          end
        end
        ST_PAUSE: begin
          if (w_qd_rise) begin
            r_state <= ST_RUN;
            r_w     <= r_resume;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_w     <= 3'b000;
        end
      endcase
    end
  end

  assign o_w         = r_w;
  assign o_running   = (r_state == ST_RUN);
  assign o_halted    = (r_state == ST_PAUSE);
  assign o_instr_cnt = r_cnt;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: beat-level behavioural model checked every cycle plus directed literal checks.
module tb_beat_sequencer;

  logic        t3, clr, qd, step, short_i, long_i, stop, brk_ena;
  logic [7:0]  pc, brk_addr;
  logic [2:0]  w;
  logic        running, halted, brk_hit;
  logic [15:0] cnt;

  int n_chk  = 0;
  int n_pass = 0;

  beat_sequencer #(.CNT_W(16), .PC_W(8)) dut (
    .i_t3(t3), .i_clr(clr), .i_qd(qd), .i_step(step), .i_short(short_i),
    .i_long(long_i), .i_stop(stop), .i_pc(pc), .i_brk_addr(brk_addr),
    .i_brk_ena(brk_ena), .o_w(w), .o_running(running), .o_halted(halted),
    .o_brk_hit(brk_hit), .o_instr_cnt(cnt)
  );

  initial t3 = 1'b1;
  always #5 t3 = ~t3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: mode 0=idle 1=run 2=pause; beat is 1..3 while running, 0 otherwise.
  int          m_mode, m_beat, m_resume;
  logic        m_qdq, m_brk;
  logic [15:0] m_cnt;

  always @(negedge t3 or negedge clr) begin
    bit rise, ends, hitb;
    int nxt;
    if (!clr) begin
      m_mode = 0; m_beat = 0; m_resume = 1; m_qdq = 0; m_brk = 0; m_cnt = 0;
    end else begin
      rise  = qd && !m_qdq;
      m_qdq = qd;
      if (m_mode == 0) begin
        if (rise) begin m_mode = 1; m_beat = 1; end
      end else if (m_mode == 1) begin
        ends = (m_beat == 1 && short_i) || (m_beat == 2 && !long_i) || (m_beat == 3);
        nxt  = ends ? 1 : m_beat + 1;
`ifdef BEAT_SEQ_BREAKPOINT_EN
        hitb = ends && brk_ena && (pc == brk_addr);
`else
        hitb = 0;
`endif
        if (ends) m_cnt = m_cnt + 16'd1;
        if (stop || (step && ends) || hitb) begin
          m_mode = 2; m_resume = nxt; m_brk = hitb; m_beat = 0;
        end else begin
          m_beat = nxt;
        end
      end else begin
        if (rise) begin m_mode = 1; m_beat = m_resume; m_brk = 0; end
      end
    end
  end

  // Outputs change on the falling edge; compare on the rising edge.
  always @(posedge t3) begin
    logic [2:0] exp_w;
    if (clr) begin
      exp_w = (m_beat == 0) ? 3'b000 : (3'b001 << (m_beat - 1));
      chk("model_w", {29'd0, w}, {29'd0, exp_w});
      chk("model_cnt", {16'd0, cnt}, {16'd0, m_cnt});
      chk("model_state", {29'd0, running, halted, brk_hit},
          {29'd0, (m_mode == 1), (m_mode == 2), m_brk});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge t3);
  endtask

  int base;

  initial begin
    clr = 0; qd = 0; step = 0; short_i = 0; long_i = 0; stop = 0;
    brk_ena = 0; pc = 8'h00; brk_addr = 8'h00;
    tick(2);
    chk("reset_w", {29'd0, w}, 32'd0);
    chk("reset_cnt", {16'd0, cnt}, 32'd0);
    chk("reset_flags", {29'd0, running, halted, brk_hit}, 32'd0);
    clr = 1;

    // Plain W1/W2 loop
    tick(1); qd = 1;
    tick(1); qd = 0; chk("run_w1", {29'd0, w}, 32'd1);
    tick(1); chk("run_w2", {29'd0, w}, 32'd2);
    tick(1); chk("run_w1b", {29'd0, w}, 32'd1); chk("run_cnt1", {16'd0, cnt}, 32'd1);
    tick(1); chk("run_w2b", {29'd0, w}, 32'd2);
    tick(1); chk("run_cnt2", {16'd0, cnt}, 32'd2);

    // Async clear in the middle of W2
    tick(1); chk("pre_clr_w", {29'd0, w}, 32'd2);
    #2 clr = 0;
    #1 chk("clr_w", {29'd0, w}, 32'd0);
    chk("clr_cnt", {16'd0, cnt}, 32'd0);
    chk("clr_run", {31'd0, running}, 32'd0);
    tick(1); clr = 1;

    // SHORT keeps W1; LONG adds W3; SHORT beats LONG
    tick(1); short_i = 1; qd = 1;
    tick(1); qd = 0; chk("short_w", {29'd0, w}, 32'd1); chk("short_cnt0", {16'd0, cnt}, 32'd0);
    tick(1); chk("short_cnt1", {16'd0, cnt}, 32'd1);
    tick(1); chk("short_cnt2", {16'd0, cnt}, 32'd2); short_i = 0; long_i = 1;
    tick(1); chk("long_w2", {29'd0, w}, 32'd2);
    tick(1); chk("long_w3", {29'd0, w}, 32'd4);
    tick(1); chk("long_w1", {29'd0, w}, 32'd1); chk("long_cnt", {16'd0, cnt}, 32'd3);
    short_i = 1;
    tick(1); chk("both_w1", {29'd0, w}, 32'd1); chk("both_cnt", {16'd0, cnt}, 32'd4);
    short_i = 0; long_i = 0;

    // STOP in W2 with QD already high: pause, no resume until a fresh rise
    tick(1); chk("stop_pre", {29'd0, w}, 32'd2); stop = 1; qd = 1;
    tick(1); stop = 0;
    chk("stop_w", {29'd0, w}, 32'd0); chk("stop_halt", {31'd0, halted}, 32'd1);
    chk("stop_cnt", {16'd0, cnt}, 32'd5);
    tick(2); chk("qd_held", {31'd0, halted}, 32'd1);
    qd = 0;
    tick(1); qd = 1;
    tick(1); chk("resume_w", {29'd0, w}, 32'd1); chk("resume_run", {31'd0, running}, 32'd1);
    // STOP in W1 resumes at W2
    qd = 0; stop = 1;
    tick(1); stop = 0; chk("stop1_halt", {31'd0, halted}, 32'd1); chk("stop1_cnt", {16'd0, cnt}, 32'd5);
    qd = 1;
    tick(1); qd = 0; chk("resume_w2", {29'd0, w}, 32'd2);
    tick(1); chk("resume_cnt", {16'd0, cnt}, 32'd6);

    // Single-step: one instruction per QD pulse
    step = 1;
    tick(2); chk("step_halt0", {31'd0, halted}, 32'd1);
    base = cnt;
    for (int i = 0; i < 3; i++) begin
      qd = 1; tick(1); qd = 0; tick(3);
      chk("step_halt", {31'd0, halted}, 32'd1);
    end
    chk("step_cnt", {16'd0, cnt}, base + 3);
    step = 0;

    // Breakpoint at PC 05
    brk_ena = 1; brk_addr = 8'h05; pc = 8'h05;
    qd = 1; tick(1); qd = 0; tick(3);
`ifdef BEAT_SEQ_BREAKPOINT_EN
    chk("brk_halt", {31'd0, halted}, 32'd1);
    chk("brk_hit", {31'd0, brk_hit}, 32'd1);
    brk_ena = 0;
    qd = 1; tick(1); qd = 0;
    chk("brk_resume_w", {29'd0, w}, 32'd1);
`else
    chk("nobrk_run", {31'd0, running}, 32'd1);
    brk_ena = 0;
    tick(1);
`endif
    chk("brk_clear", {31'd0, brk_hit}, 32'd0);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
